md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the next-generation pipelined MIPS core.
- Sits beside the Execute-stage ALU and takes operands after forwarding.
- Exposes a busy/start handshake that the hazard logic uses to stall Decode when an MD-class instruction meets a busy unit.
- Supports flush to cancel an in-flight operation, for example on branch or exception squash.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MULT_CYCLES, 5, cycles busy is high after a multiply start; must be ≥1.
- DIV_CYCLES, 10, cycles busy is high after a divide start; must be ≥1.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  issue operation op in this cycle (Execute stage)
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 are no-op
- a  in  WIDTH  rs operand (forwarded)
- b  in  WIDTH  rt operand (forwarded)
- flush  in  1  cancel the in-flight op and ignore start in this cycle
- busy  out  1  operation in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: while reset=0, and asynchronously on assertion, busy=0, hi=0, lo=0, counter=0, state IDLE.
  - Reset mid-operation discards the result.
- States: IDLE and RUN.
- IDLE, start=1, flush=0, op in {MULT, MULTU}:
  - Latch operands and the computed result into internal pending registers.
  - Load counter=MULT_CYCLES and go to RUN.
  - busy goes high from the next cycle.
- IDLE, start=1, flush=0, op in {DIV, DIVU}: same as multiply, with counter=DIV_CYCLES.
- IDLE, start=1, flush=0, op=MTHI: hi<=a at the next edge. busy stays 0. lo is unchanged.
- IDLE, start=1, flush=0, op=MTLO: lo<=a at the next edge. busy stays 0. hi is unchanged.
- IDLE, op 6 or 7: no effect.
- RUN:
  - Counter decrements each cycle.
  - On the edge where the counter goes 1→0, {hi,lo}<=pending, busy<=0, and state returns to IDLE.
  - Consequently busy is high for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
  - hi and lo are readable with new values in the first cycle busy=0.
- start while busy=1: ignored. Hazard logic guarantees stall; the unit does not queue.
- Back-to-back: a new start is accepted in the first cycle busy=0.
- flush=1 in RUN: next edge gives state IDLE, busy=0, hi and lo keep their pre-operation values.
- flush=1 with start=1: flush wins and the start is dropped, including MTHI/MTLO.
- flush in IDLE has no other effect.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH product; hi = upper half, lo = lower half.
  - MULTU: unsigned WIDTH×WIDTH → 2·WIDTH product; hi = upper half, lo = lower half.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b=0), DIV or DIVU: lo = all ones, hi = a.
  - DIV overflow (a = most negative, b = −1): lo = a, hi = 0.
- Operands are sampled only at the accepted start. Changes to a or b during RUN have no effect.

Test Plan:
- Reset release, then MULT a=0xFFFFFFFE (−2), b=3 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x1234 → hi=0x1234 next cycle with busy never asserted. Then MTLO with flush=1 in the same cycle → lo unchanged.
- Preload hi=0xAA and lo=0xBB via MTHI/MTLO. Start MULT 3×4, then flush at busy cycle 2 → busy=0 next cycle, hi=0xAA, lo=0xBB. Then a DIVU start on the same cycle as a second start while busy → second start ignored and only the DIVU result appears.
- Assert reset (0) at busy cycle 3 of DIV → busy, hi and lo go to 0 immediately without waiting for a clock edge. After release, no stale result is written.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers, busy/start handshake and flush
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] pend;
    logic [2*WIDTH-1:0] prod_s, prod_u, result;
    logic [WIDTH-1:0]   dvs_s, dvs_u, q_s, r_s, q_u, r_u;
    logic               div_zero, div_ovf;

    // Compute the full result from the live operands; it is captured only at an accepted start.
    // The signed divisor is forced to 1 on overflow so the divider never sees MIN/-1 and
    // naturally yields quotient=a, remainder=0; divide-by-zero is patched in afterwards.
    always_comb begin
        div_zero = (b == '0);
        div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        dvs_s    = (div_zero || div_ovf) ? WIDTH'(1) : b;
        dvs_u    = div_zero ? WIDTH'(1) : b;
        q_s      = $signed(a) / $signed(dvs_s);
        r_s      = $signed(a) % $signed(dvs_s);
        q_u      = a / dvs_u;
        r_u      = a % dvs_u;
        result   = (op == OP_MULT)  ? prod_s :
                   (op == OP_MULTU) ? prod_u :
                   div_zero         ? {a, {WIDTH{1'b1}}} :
                   (op == OP_DIV)   ? {r_s, q_s} : {r_u, q_u};
    end

    // Control FSM: issue from IDLE, count down in RUN, commit pending result on the 1->0 step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            pend  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        pend  <= result;
                        cnt   <= CNT_W'(MULT_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        pend  <= result;
                        cnt   <= CNT_W'(DIV_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                    OP_MTHI: hi <= a;
                    OP_MTLO: lo <= a;
                    default: ;
                endcase
            end
        end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                {hi, lo} <= pend;
                busy     <= 1'b0;
                state    <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven plus scoreboard checks of md_unit timing, arithmetic, flush and reset
module tb_md_unit;
    logic        clk, reset, start, flush, busy;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        int          n;
        logic [31:0] hi, lo;
    } vec_t;

    typedef struct {
        int          n;
        logic [31:0] hi, lo;
    } exp_t;

    vec_t tbl[9];
    exp_t sb[$];

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Count remaining busy cycles (c0 already observed), then pop and compare.
    task automatic wait_done(input string nm, input int c0);
        int   cyc;
        exp_t e;
        cyc = c0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({nm, "_busy_cycles"}, 32'(cyc), 32'(e.n));
        chk({nm, "_hi"}, hi, e.hi);
        chk({nm, "_lo"}, lo, e.lo);
    endtask

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int n, input logic [31:0] eh,
                         input logic [31:0] el);
        sb.push_back('{n, eh, el});
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        wait_done(nm, 0);
    endtask

    initial begin
        tbl[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{3'd3, 32'd7,         32'd0,         10, 32'd7,         32'hFFFF_FFFF};
        tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000};
        tbl[5] = '{3'd3, 32'd100,       32'd7,         10, 32'd2,         32'd14};
        tbl[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};
        tbl[7] = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 5,  32'hC000_0000, 32'h8000_0000};
        tbl[8] = '{3'd2, 32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF};

        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd7;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (tbl[i])
            issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].n,
                  tbl[i].hi, tbl[i].lo);

        // No-op codes leave state alone.
        start = 1'b1; op = 3'd6; a = 32'h1111_1111;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk("noop_hi", hi, 32'd5);

        // MTHI writes hi only, never raises busy; MTLO with flush is dropped.
        start = 1'b1; op = 3'd4; a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, 32'hFFFF_FFFF);
        start = 1'b1; op = 3'd5; a = 32'h5555; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("mtlo_flush_lo", lo, 32'hFFFF_FFFF);
        chk("mtlo_flush_hi", hi, 32'h1234);

        // Preload, then flush a multiply at busy cycle 2.
        start = 1'b1; op = 3'd4; a = 32'hAA;
        @(negedge clk);
        op = 3'd5; a = 32'hBB;
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("flush_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'hAA);
        chk("flush_lo", lo, 32'hBB);
        repeat (6) @(negedge clk);
        chk("flush_no_late_lo", lo, 32'hBB);

        // DIVU followed by an ignored start while busy.
        sb.push_back('{10, 32'd2, 32'd6});
        start = 1'b1; op = 3'd3; a = 32'd20; b = 32'd3;
        @(negedge clk);
        op = 3'd0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("divu_ign", 1);
        repeat (6) @(negedge clk);
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk("ign_lo", lo, 32'd6);

        // Asynchronous reset at busy cycle 3 of a divide.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
